// File: rtl/mem_access_stage_mc.sv
// Multi-cycle memory-access pipeline stage: captures execute results, runs one
// req/gnt/rvalid data-memory access per instruction and hands aligned results to write-back.
module mem_access_stage_mc #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                e_to_m_valid,
    output logic                m_allow_in,
    input  logic                w_allow_in,
    output logic                m_to_w_valid,
    input  logic                e_is_load,
    input  logic                e_is_store,
    input  logic [2:0]          e_funct3,
    input  logic [ADDR_W-1:0]   e_addr,
    input  logic [XLEN-1:0]     e_wdata,
    input  logic [4:0]          e_rd,
    input  logic [31:0]         e_pc,
    output logic [4:0]          m_rd,
    output logic [31:0]         m_pc,
    output logic                m_is_load,
    output logic [XLEN-1:0]     m_valM,
    output logic [1:0]          m_exc,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [XLEN/8-1:0]   dmem_wstrb,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata,
    input  logic                dmem_err
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t             state;
    logic               m_valid;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         funct3_q;
    logic [OFF_W-1:0]   off_q;

    logic               capture;
    logic               is_mem;
    logic               illegal;
    logic               misaligned;
    logic [OFF_W-1:0]   off;
    logic [1:0]         sz;
    logic [7:0]         off8;
    logic [7:0]         mask8;
    logic [7:0]         strb8;
    logic [NB-1:0]      wstrb_new;
    logic [XLEN-1:0]    wdata_new;
    logic [XLEN-1:0]    shifted;
    logic [63:0]        s64;
    logic [63:0]        r64;
    logic [XLEN-1:0]    load_data;

    assign m_allow_in   = ~m_valid | ((state == DONE) & w_allow_in);
    assign m_to_w_valid = m_valid & (state == DONE);
    assign capture      = m_allow_in & e_to_m_valid;
    assign is_mem       = e_is_load | e_is_store;
    assign off          = e_addr[OFF_W-1:0];
    // funct3[1:0] is log2 of the access size for every legal encoding
    assign sz           = e_funct3[1:0];
    assign off8         = 8'(off);
    assign mask8        = (8'd1 << sz) - 8'd1;
    assign misaligned   = |(off8 & mask8);
    assign strb8        = 8'((16'd1 << (5'd1 << sz)) - 16'd1);
    assign wstrb_new    = NB'(16'(strb8) << off);

    always_comb begin
        illegal = 1'b0;
        if (e_is_load) begin
            case (e_funct3)
                3'd3, 3'd6: illegal = (XLEN != 64);
                3'd7:       illegal = 1'b1;
                default:    illegal = 1'b0;
            endcase
        end else if (e_is_store) begin
            illegal = e_funct3[2] | ((e_funct3[1:0] == 2'd3) && (XLEN != 64));
        end
    end

    always_comb begin
        wdata_new = '0;
        for (int i = 0; i < NB; i++) begin
            case (sz)
                2'd0:    wdata_new[i*8 +: 8] = e_wdata[7:0];
                2'd1:    wdata_new[i*8 +: 8] = e_wdata[(i % 2)*8 +: 8];
                2'd2:    wdata_new[i*8 +: 8] = e_wdata[(i % 4)*8 +: 8];
                default: wdata_new[i*8 +: 8] = e_wdata[i*8 +: 8];
            endcase
        end
    end

    // Load alignment/extension is done at 64 bits so both XLEN widths share one path
    always_comb begin
        shifted = dmem_rdata >> {off_q, 3'b000};
        s64     = 64'(shifted);
        case (funct3_q)
            3'd0:    r64 = {{56{s64[7]}}, s64[7:0]};
            3'd1:    r64 = {{48{s64[15]}}, s64[15:0]};
            3'd2:    r64 = (XLEN == 64) ? {{32{s64[31]}}, s64[31:0]} : s64;
            3'd4:    r64 = {56'd0, s64[7:0]};
            3'd5:    r64 = {48'd0, s64[15:0]};
            3'd6:    r64 = {32'd0, s64[31:0]};
            default: r64 = s64;
        endcase
        load_data = XLEN'(r64);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            m_valid    <= 1'b0;
            cnt        <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
            m_rd       <= '0;
            m_pc       <= '0;
            m_is_load  <= 1'b0;
            m_valM     <= '0;
            m_exc      <= 2'b00;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wstrb <= '0;
            dmem_wdata <= '0;
        end else if (m_allow_in) begin
            m_valid <= e_to_m_valid;
            if (capture) begin
                m_rd       <= e_rd;
                m_pc       <= e_pc;
                m_is_load  <= e_is_load;
                m_valM     <= '0;
                funct3_q   <= e_funct3;
                off_q      <= off;
                cnt        <= '0;
                dmem_we    <= e_is_store & ~e_is_load;
                dmem_addr  <= {e_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                dmem_wstrb <= wstrb_new;
                dmem_wdata <= wdata_new;
                if (!is_mem) begin
                    m_exc <= 2'b00;
                    state <= DONE;
                end else if (illegal) begin
                    m_exc <= 2'b11;
                    state <= DONE;
                end else if (misaligned) begin
                    m_exc <= 2'b01;
                    state <= DONE;
                end else begin
                    m_exc    <= 2'b00;
                    dmem_req <= 1'b1;
                    state    <= REQ;
                end
            end else begin
                state <= IDLE;
            end
        end else begin
            case (state)
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        cnt      <= '0;
                        state    <= WAIT;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        dmem_req <= 1'b0;
                        cnt      <= '0;
                        m_exc    <= 2'b10;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        if (dmem_err) m_exc <= 2'b10;
                        if (m_is_load) m_valM <= load_data;
                        state <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage_mc.sv
// Bench for mem_access_stage_mc (XLEN=32, TIMEOUT=8): directed cases plus random
// accesses checked against an arithmetic model of the stage's load/store rules.
module tb_mem_access_stage_mc;
  localparam int XLEN = 32;
  localparam int ADDR_W = 32;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic e_to_m_valid = 1'b0, m_allow_in, w_allow_in = 1'b0, m_to_w_valid;
  logic e_is_load = 1'b0, e_is_store = 1'b0;
  logic [2:0] e_funct3 = '0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_pc = '0;
  logic [4:0] e_rd = '0, m_rd;
  logic [31:0] m_pc, m_valM;
  logic m_is_load;
  logic [1:0] m_exc;
  logic dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0] dmem_wstrb;
  logic dmem_gnt = 1'b0, dmem_rvalid = 1'b0, dmem_err = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic allowed; int issue_cyc; logic req0; logic [31:0] addr; logic we;
    logic [3:0] wstrb; logic [31:0] wdata; int req_cycles; int lat; logic done;
    logic [1:0] exc; logic [31:0] valm; logic [4:0] rd; logic [31:0] pc; logic is_load;
  } obs_t;

  typedef struct {
    logic req; logic [1:0] exc; logic [31:0] addr; logic [3:0] wstrb;
    logic [31:0] wdata; logic [31:0] valm;
  } exp_t;

  mem_access_stage_mc #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .e_to_m_valid(e_to_m_valid), .m_allow_in(m_allow_in),
    .w_allow_in(w_allow_in), .m_to_w_valid(m_to_w_valid), .e_is_load(e_is_load),
    .e_is_store(e_is_store), .e_funct3(e_funct3), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_rd(e_rd), .e_pc(e_pc), .m_rd(m_rd), .m_pc(m_pc), .m_is_load(m_is_load),
    .m_valM(m_valM), .m_exc(m_exc), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .dmem_err(dmem_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: expected bus request and result of one access
  function automatic exp_t model(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdat, input logic err);
    exp_t e;
    int nb, off;
    bit sgn, legal;
    longint v;
    e.req = 0; e.exc = 0; e.wstrb = 0; e.wdata = 0; e.valm = 0;
    off = int'(addr % 4);
    e.addr = addr - 32'(off);
    legal = 1; sgn = 0; nb = 4;
    case (f3)
      3'd0: begin nb = 1; sgn = 1; end
      3'd1: begin nb = 2; sgn = 1; end
      3'd2: nb = 4;
      3'd4: nb = 1;
      3'd5: nb = 2;
      default: legal = 0;
    endcase
    if (st && f3 > 3'd2) legal = 0;
    if (!(ld || st)) return e;
    if (!legal) begin e.exc = 2'b11; return e; end
    if (off % nb != 0) begin e.exc = 2'b01; return e; end
    e.req = 1;
    e.exc = err ? 2'b10 : 2'b00;
    e.wstrb = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
    if (ld) begin
      v = longint'(rdat >> (8 * off)) % (longint'(1) << (8 * nb));
      if (sgn && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      e.valm = 32'(v);
    end
    return e;
  endfunction

  // driver tasks
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic retire;
    w_allow_in = 1'b1;
    e_to_m_valid = 1'b0;
    tick();
    w_allow_in = 1'b0;
  endtask

  // Issues one op (from IDLE or DONE), plays the memory side, stops with the op in DONE.
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdat, input logic err,
                            input int gnt_dly, input int rv_dly,
                            input logic [4:0] rd, input logic [31:0] pc, output obs_t o);
    int n;
    logic granted;
    o.req_cycles = 0;
    e_is_load = ld; e_is_store = st; e_funct3 = f3; e_addr = addr; e_wdata = wd;
    e_rd = rd; e_pc = pc; e_to_m_valid = 1'b1; w_allow_in = 1'b1;
    #1;
    o.allowed = m_allow_in;
    o.issue_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    e_to_m_valid = 1'b0; w_allow_in = 1'b0;
    e_addr = $urandom; e_wdata = $urandom; e_rd = 5'($urandom); e_pc = $urandom;
    o.req0 = dmem_req; o.addr = dmem_addr; o.we = dmem_we;
    o.wstrb = dmem_wstrb; o.wdata = dmem_wdata;
    n = 0;
    granted = 1'b0;
    while (dmem_req && n < 40 && !granted) begin
      o.req_cycles++;
      dmem_gnt = (n == gnt_dly);
      granted = dmem_gnt;
      tick();
      dmem_gnt = 1'b0;
      n++;
    end
    if (granted) begin
      repeat (rv_dly) tick();
      dmem_rvalid = 1'b1; dmem_rdata = rdat; dmem_err = err;
      tick();
      dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = $urandom;
    end
    n = 0;
    while (!m_to_w_valid && n < 20) begin
      tick();
      n++;
    end
    o.lat = n; o.done = m_to_w_valid; o.exc = m_exc; o.valm = m_valM;
    o.rd = m_rd; o.pc = m_pc; o.is_load = m_is_load;
  endtask

  // tests
  task automatic test_reset;
    #1;
    n_cmp++; if (m_to_w_valid !== 1'b0) begin n_bad++; $display("FAIL reset_to_w_valid got=%0b exp=0", m_to_w_valid); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%0b exp=0", dmem_req); end
    n_cmp++; if (m_allow_in !== 1'b1) begin n_bad++; $display("FAIL reset_allow_in got=%0b exp=1", m_allow_in); end
    n_cmp++; if ({m_rd, m_pc, m_is_load, m_valM, m_exc} !== '0) begin n_bad++; $display("FAIL reset_m_outputs rd=%0h pc=%0h ld=%0b val=%0h exc=%0h exp=all zero", m_rd, m_pc, m_is_load, m_valM, m_exc); end
  endtask

  task automatic test_directed;
    obs_t o;
    run_access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80A5_5A5A, 0, 1, 1, 5'd3, 32'h1000, o);
    n_cmp++; if (o.addr !== 32'h100) begin n_bad++; $display("FAIL lb_addr got=%0h exp=100", o.addr); end
    n_cmp++; if (o.valm !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_valM got=%0h exp=ffffff80", o.valm); end
    n_cmp++; if (o.exc !== 2'b00 || o.lat !== 0) begin n_bad++; $display("FAIL lb_exc_lat exc=%0h lat=%0d exp=0/0", o.exc, o.lat); end
    retire();
    run_access(0, 1, 3'd1, 32'h202, 32'h0000_1234, 32'h0, 0, 0, 0, 5'd0, 32'h1004, o);
    n_cmp++; if (o.addr !== 32'h200 || o.we !== 1'b1) begin n_bad++; $display("FAIL sh_addr_we got=%0h/%0b exp=200/1", o.addr, o.we); end
    n_cmp++; if (o.wstrb !== 4'b1100) begin n_bad++; $display("FAIL sh_wstrb got=%0b exp=1100", o.wstrb); end
    n_cmp++; if (o.wdata !== 32'h1234_1234) begin n_bad++; $display("FAIL sh_wdata got=%0h exp=12341234", o.wdata); end
    run_access(1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0, 0, 5'd4, 32'h1008, o);
    n_cmp++; if (o.req0 !== 1'b0 || o.exc !== 2'b01 || o.lat !== 0) begin n_bad++; $display("FAIL lw_misaligned req=%0b exc=%0h lat=%0d exp=0/1/0", o.req0, o.exc, o.lat); end
    run_access(1, 0, 3'd3, 32'h108, 32'h0, 32'h0, 0, 0, 0, 5'd5, 32'h100C, o);
    n_cmp++; if (o.req0 !== 1'b0 || o.exc !== 2'b11) begin n_bad++; $display("FAIL ld_illegal req=%0b exc=%0h exp=0/3", o.req0, o.exc); end
    retire();
  endtask

  task automatic test_timeout;
    obs_t o;
    run_access(1, 0, 3'd2, 32'h100, 32'h0, 32'h0, 0, 1000, 0, 5'd7, 32'h2000, o);
    n_cmp++; if (o.req_cycles !== TIMEOUT) begin n_bad++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", o.req_cycles, TIMEOUT); end
    n_cmp++; if (o.exc !== 2'b10 || o.done !== 1'b1 || dmem_req !== 1'b0) begin n_bad++; $display("FAIL timeout_result exc=%0h done=%0b req=%0b exp=2/1/0", o.exc, o.done, dmem_req); end
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    n_cmp++; if (m_valM !== 32'h0 || m_exc !== 2'b10 || m_to_w_valid !== 1'b1) begin n_bad++; $display("FAIL stale_rvalid_done val=%0h exc=%0h v=%0b exp=0/2/1", m_valM, m_exc, m_to_w_valid); end
    retire();
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    n_cmp++; if (m_to_w_valid !== 1'b0) begin n_bad++; $display("FAIL stale_rvalid_idle got=%0b exp=0", m_to_w_valid); end
    run_access(1, 0, 3'd2, 32'h104, 32'h0, 32'hCAFE_0001, 0, 0, 0, 5'd8, 32'h2004, o);
    n_cmp++; if (o.valm !== 32'hCAFE_0001 || o.exc !== 2'b00) begin n_bad++; $display("FAIL after_timeout val=%0h exc=%0h exp=cafe0001/0", o.valm, o.exc); end
    retire();
  endtask

  task automatic test_stall;
    obs_t o;
    run_access(1, 0, 3'd5, 32'h42, 32'h0, 32'hBEEF_0000, 0, 2, 2, 5'd9, 32'h3000, o);
    n_cmp++; if (o.valm !== 32'h0000_BEEF) begin n_bad++; $display("FAIL stall_lhu got=%0h exp=beef", o.valm); end
    e_to_m_valid = 1'b1; e_is_load = 1'b1; e_is_store = 1'b0; e_funct3 = 3'd2;
    e_addr = 32'h80; e_rd = 5'd31; e_pc = 32'h3FFC; w_allow_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (m_allow_in !== 1'b0 || m_to_w_valid !== 1'b1) begin n_bad++; $display("FAIL stall_handshake cyc%0d allow=%0b v=%0b exp=0/1", i, m_allow_in, m_to_w_valid); end
      n_cmp++; if (m_valM !== 32'h0000_BEEF || m_rd !== 5'd9 || m_pc !== 32'h3000) begin n_bad++; $display("FAIL stall_hold cyc%0d val=%0h rd=%0d pc=%0h exp=beef/9/3000", i, m_valM, m_rd, m_pc); end
      tick();
    end
    run_access(0, 1, 3'd0, 32'h51, 32'h0000_00A7, 32'h0, 0, 0, 0, 5'd10, 32'h3004, o);
    n_cmp++; if (o.allowed !== 1'b1 || o.req0 !== 1'b1 || o.wstrb !== 4'b0010) begin n_bad++; $display("FAIL release_capture allow=%0b req=%0b strb=%0b exp=1/1/0010", o.allowed, o.req0, o.wstrb); end
    n_cmp++; if (o.wdata !== 32'hA7A7_A7A7 || o.rd !== 5'd10 || o.pc !== 32'h3004) begin n_bad++; $display("FAIL release_fields wdata=%0h rd=%0d pc=%0h exp=a7a7a7a7/10/3004", o.wdata, o.rd, o.pc); end
    retire();
  endtask

  task automatic test_back_to_back;
    obs_t o1, o2, o3;
    run_access(1, 0, 3'd4, 32'h21, 32'h0, 32'h0000_FF00, 0, 0, 0, 5'd1, 32'h4000, o1);
    run_access(1, 0, 3'd1, 32'h32, 32'h0, 32'h8001_0000, 0, 0, 0, 5'd2, 32'h4004, o2);
    run_access(0, 1, 3'd2, 32'h44, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 5'd3, 32'h4008, o3);
    n_cmp++; if (o2.issue_cyc - o1.issue_cyc !== 3 || o3.issue_cyc - o2.issue_cyc !== 3) begin n_bad++; $display("FAIL b2b_spacing got=%0d,%0d exp=3,3", o2.issue_cyc - o1.issue_cyc, o3.issue_cyc - o2.issue_cyc); end
    n_cmp++; if (o1.valm !== 32'h0000_00FF || o2.valm !== 32'hFFFF_8001) begin n_bad++; $display("FAIL b2b_loads got=%0h,%0h exp=ff,ffff8001", o1.valm, o2.valm); end
    n_cmp++; if (o3.wstrb !== 4'hF || o3.wdata !== 32'hDEAD_BEEF || o3.valm !== 32'h0) begin n_bad++; $display("FAIL b2b_store strb=%0h wdata=%0h val=%0h exp=f/deadbeef/0", o3.wstrb, o3.wdata, o3.valm); end
    retire();
  endtask

  task automatic test_async_reset;
    obs_t o;
    e_is_load = 1'b1; e_is_store = 1'b0; e_funct3 = 3'd2; e_addr = 32'h10;
    e_rd = 5'd12; e_pc = 32'h5000; e_to_m_valid = 1'b1; w_allow_in = 1'b1;
    tick();
    e_to_m_valid = 1'b0; w_allow_in = 1'b0;
    n_cmp++; if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_req got=%0b exp=1", dmem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dmem_req !== 1'b0 || m_to_w_valid !== 1'b0 || m_allow_in !== 1'b1) begin n_bad++; $display("FAIL rst_in_req req=%0b v=%0b allow=%0b exp=0/0/1", dmem_req, m_to_w_valid, m_allow_in); end
    @(negedge clk) rst_n = 1'b1;
    e_to_m_valid = 1'b1; w_allow_in = 1'b1;
    tick();
    e_to_m_valid = 1'b0; w_allow_in = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dmem_req !== 1'b0 || m_to_w_valid !== 1'b0 || m_allow_in !== 1'b1 || m_rd !== 5'd0 || m_is_load !== 1'b0) begin n_bad++; $display("FAIL rst_in_wait req=%0b v=%0b allow=%0b rd=%0d ld=%0b exp=0/0/1/0/0", dmem_req, m_to_w_valid, m_allow_in, m_rd, m_is_load); end
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_access(1, 0, 3'd1, 32'h16, 32'h0, 32'h7FFF_1234, 0, 1, 0, 5'd13, 32'h5004, o);
    n_cmp++; if (o.valm !== 32'h0000_7FFF || o.exc !== 2'b00 || o.rd !== 5'd13) begin n_bad++; $display("FAIL post_reset_lh val=%0h exc=%0h rd=%0d exp=7fff/0/13", o.valm, o.exc, o.rd); end
    retire();
  endtask

  task automatic test_random;
    obs_t o;
    exp_t e;
    logic ld, st, err;
    logic [2:0] f3;
    logic [31:0] addr, wd, rdat, pc;
    logic [4:0] rd;
    int kind, gd, rvd;
    logic [2:0] legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 5);
      ld = (kind < 3); st = (kind == 3 || kind == 4);
      f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      addr = $urandom; wd = $urandom; rdat = $urandom; pc = $urandom; rd = 5'($urandom);
      err = ($urandom_range(0, 7) == 0);
      gd = $urandom_range(0, 3); rvd = $urandom_range(0, 2);
      run_access(ld, st, f3, addr, wd, rdat, err, gd, rvd, rd, pc, o);
      e = model(ld, st, f3, addr, wd, rdat, err);
      n_cmp++; if (o.allowed !== 1'b1 || o.done !== 1'b1 || o.lat !== 0) begin n_bad++; $display("FAIL rand%0d_flow allow=%0b done=%0b lat=%0d exp=1/1/0", k, o.allowed, o.done, o.lat); end
      n_cmp++; if (o.req0 !== e.req) begin n_bad++; $display("FAIL rand%0d_req got=%0b exp=%0b", k, o.req0, e.req); end
      n_cmp++; if (o.exc !== e.exc) begin n_bad++; $display("FAIL rand%0d_exc got=%0h exp=%0h", k, o.exc, e.exc); end
      n_cmp++; if (o.rd !== rd || o.pc !== pc || o.is_load !== ld) begin n_bad++; $display("FAIL rand%0d_regs rd=%0d pc=%0h ld=%0b exp=%0d/%0h/%0b", k, o.rd, o.pc, o.is_load, rd, pc, ld); end
      if (e.exc != 2'b10) begin
        n_cmp++; if (o.valm !== e.valm) begin n_bad++; $display("FAIL rand%0d_valM got=%0h exp=%0h", k, o.valm, e.valm); end
      end
      if (e.req) begin
        n_cmp++; if (o.addr !== e.addr || o.we !== st || o.req_cycles !== gd + 1) begin n_bad++; $display("FAIL rand%0d_bus addr=%0h we=%0b reqc=%0d exp=%0h/%0b/%0d", k, o.addr, o.we, o.req_cycles, e.addr, st, gd + 1); end
        if (st) begin
          n_cmp++; if (o.wstrb !== e.wstrb || o.wdata !== e.wdata) begin n_bad++; $display("FAIL rand%0d_store strb=%0h wdata=%0h exp=%0h/%0h", k, o.wstrb, o.wdata, e.wstrb, e.wdata); end
        end
      end
      if ($urandom_range(0, 1) == 1) retire();
    end
    retire();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    tick();
    test_directed();
    test_timeout();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
